// File: rtl/mult_div.sv
// mult_div: EX-stage multiply/divide unit; single-cycle 32x32 multiply and
// 32-step restoring divide, with the result held as {hi, lo} until replaced.
module mult_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hold,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    output logic        done,
    output logic [63:0] result
);
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] op_a, op_b, rem, rem_nx, quo_nx, abs_1, abs_2;
    logic [5:0]  cnt;
    logic        mul_sgn, neg_q, neg_r;
    logic        is_mul, is_div, div_sgn, ge;
    logic [32:0] shifted, diff;
    logic [63:0] ext_a, ext_b, product;

    assign is_mul  = funct == F_MULT || funct == F_MULTU;
    assign is_div  = funct == F_DIV || funct == F_DIVU;
    assign div_sgn = funct == F_DIV;
    assign abs_1   = (div_sgn && operand_1[31]) ? -operand_1 : operand_1;
    assign abs_2   = (div_sgn && operand_2[31]) ? -operand_2 : operand_2;
    assign done    = state == DONE;

    // Sign-extending only for MULT lets one 64-bit multiplier serve both forms.
    assign ext_a   = {{32{mul_sgn & op_a[31]}}, op_a};
    assign ext_b   = {{32{mul_sgn & op_b[31]}}, op_b};
    assign product = ext_a * ext_b;

    // op_a doubles as the dividend/quotient shift register during DIV.
    assign shifted = {rem, op_a[31]};
    assign diff    = shifted - {1'b0, op_b};
    assign ge      = ~diff[32];
    assign rem_nx  = ge ? diff[31:0] : shifted[31:0];
    assign quo_nx  = {op_a[30:0], ge};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = is_mul ? MUL : is_div ? (operand_2 == 32'd0 ? DONE : DIV) : IDLE;
            MUL:     state_nx = DONE;
            DIV:     state_nx = cnt == 6'd31 ? DONE : DIV;
            default: state_nx = hold ? DONE : IDLE;
        endcase
        if (flush)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            rem     <= 32'd0;
            cnt     <= 6'd0;
            mul_sgn <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= 64'd0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        op_a    <= operand_1;
                        op_b    <= operand_2;
                        mul_sgn <= funct == F_MULT;
                    end else if (is_div && operand_2 == 32'd0) begin
                        result <= {operand_1, 32'hFFFF_FFFF};
                    end else if (is_div) begin
                        op_a  <= abs_1;
                        op_b  <= abs_2;
                        rem   <= 32'd0;
                        cnt   <= 6'd0;
                        neg_q <= div_sgn && (operand_1[31] ^ operand_2[31]);
                        neg_r <= div_sgn && operand_1[31];
                    end
                end
                MUL: result <= product;
                DIV: begin
                    op_a <= quo_nx;
                    rem  <= rem_nx;
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'd31)
                        result <= {neg_r ? -rem_nx : rem_nx, neg_q ? -quo_nx : quo_nx};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: randomized and directed checks of mult_div against an arithmetic model.
module tb_mult_div;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst, flush, hold, done;
    logic [5:0]  funct;
    logic [31:0] operand_1, operand_2;
    logic [63:0] result, last_exp;
    int          vectors = 0;
    int          miscompares = 0;

    mult_div dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold), .funct(funct),
        .operand_1(operand_1), .operand_2(operand_2), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = (f == F_MULT || f == F_DIV) ? longint'($signed(a)) : longint'({32'b0, a});
        sb = (f == F_MULT || f == F_DIV) ? longint'($signed(b)) : longint'({32'b0, b});
        if (f == F_MULT || f == F_MULTU) begin
            p = sa * sb;
            return p;
        end
        if (b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called at a falling edge; returns one falling edge after done is seen.
    task automatic issue(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
        int n, lat;
        lat = (f == F_MULT || f == F_MULTU) ? 2 : (b == 32'd0) ? 1 : 33;
        funct = f;
        operand_1 = a;
        operand_2 = b;
        n = 0;
        forever begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done || n >= 40)
                break;
            operand_1 = $urandom;
            operand_2 = $urandom;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check(tag, result, exp);
        last_exp = exp;
        funct = 6'd0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0]  fs [4];
        logic [5:0]  f;
        logic [31:0] a, b;
        fs = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        rst = 1'b0; flush = 1'b0; hold = 1'b0; funct = 6'd0;
        operand_1 = 32'd0; operand_2 = 32'd0;
        #1;
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        issue("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        issue("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
        issue("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue("divu_100_7", F_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
        issue("divu_zero", F_DIVU, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF});
        issue("div_zero", F_DIV, 32'h8000_0001, 32'd0, {32'h8000_0001, 32'hFFFF_FFFF});
        issue("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});

        funct = F_MULTU; operand_1 = 32'hFFFF_FFFF; operand_2 = 32'd2;
        repeat (2) @(negedge clk);
        check("b2b_done1", 64'(done), 64'd1);
        @(negedge clk);
        check("b2b_idle", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        check("b2b_done2", 64'(done), 64'd1);
        check("b2b_result", result, 64'h0000_0001_FFFF_FFFE);
        last_exp = 64'h0000_0001_FFFF_FFFE;
        funct = 6'd0;
        @(negedge clk);

        hold = 1'b1;
        issue("hold", F_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
        for (int i = 0; i < 3; i++) begin
            check("hold_done", 64'(done), 64'd1);
            check("hold_result", result, {32'd2, 32'd14});
            if (i < 2) @(negedge clk);
        end
        hold = 1'b0;
        @(negedge clk);
        check("hold_release", 64'(done), 64'd0);

        funct = F_DIV; operand_1 = 32'd1000; operand_2 = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        check("flush_done", 64'(done), 64'd0);
        check("flush_result", result, last_exp);
        flush = 1'b0;
        funct = 6'd0;
        @(negedge clk);
        check("flush_idle", 64'(done), 64'd0);
        issue("after_flush", F_DIV, 32'd1000, 32'd3, {32'd1, 32'd333});

        funct = F_DIV; operand_1 = 32'd50; operand_2 = 32'd7;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", result, 64'd0);
        funct = F_MULT; operand_1 = 32'd3; operand_2 = 32'd4;
        @(negedge clk);
        rst = 1'b1;
        issue("rst_mul", F_MULT, 32'd3, 32'd4, 64'd12);

        for (int i = 0; i < 30; i++) begin
            f = fs[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = $urandom_range(0, 255);
                default: ;
            endcase
            issue("rand", f, a, b, model(f, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
